// File: rtl/alu_secuencial.sv
// Registered execute unit: single-cycle logic/arithmetic plus iterative
// unsigned shift-add multiply and restoring divide behind a start/done handshake.
module alu_secuencial #(
    parameter int ANCHO = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inicio,
    input  logic [3:0]       aluOP,
    input  logic [ANCHO-1:0] datoRN,
    input  logic [ANCHO-1:0] datoRM,
    output logic             listo,
    output logic             valido,
    output logic [ANCHO-1:0] resultadoALU,
    output logic [ANCHO-1:0] resultadoAlto,
    output logic             zero,
    output logic             negativo,
    output logic             acarreo,
    output logic             desbordamiento,
    output logic             divCero
);

    localparam int SH = $clog2(ANCHO);
    localparam int CW = $clog2(ANCHO + 1);

    typedef enum logic {
        REPOSO,
        ITERA
    } estado_t;

    estado_t          estado;
    logic [CW-1:0]    cuenta;
    logic             es_mul;
    logic [ANCHO-1:0] m;
    logic [ANCHO-1:0] hi;
    logic [ANCHO-1:0] lo;

    logic [ANCHO:0]   suma_ab;
    logic [ANCHO:0]   resta_ab;
    logic             slt;
    logic             iterativo;
    logic [ANCHO-1:0] res_c;
    logic [ANCHO-1:0] alto_c;
    logic             acarreo_c;
    logic             desb_c;
    logic             divcero_c;

    logic [ANCHO:0]   suma_it;
    logic [ANCHO:0]   desp;
    logic [ANCHO:0]   resta_it;
    logic [ANCHO-1:0] hi_n;
    logic [ANCHO-1:0] lo_n;

    assign suma_ab   = {1'b0, datoRN} + {1'b0, datoRM};
    assign resta_ab  = {1'b0, datoRN} - {1'b0, datoRM};
    assign slt       = $signed(datoRN) < $signed(datoRM);
    assign iterativo = (aluOP == 4'b1001) ||
                       (aluOP == 4'b1010 && datoRM != '0);

    always_comb begin
        res_c     = '0;
        alto_c    = '0;
        acarreo_c = 1'b0;
        desb_c    = 1'b0;
        divcero_c = 1'b0;
        case (aluOP)
            4'b0000: res_c = datoRN & datoRM;
            4'b0001: res_c = datoRN | datoRM;
            4'b0010: begin
                res_c     = suma_ab[ANCHO-1:0];
                acarreo_c = suma_ab[ANCHO];
                desb_c    = (datoRN[ANCHO-1] == datoRM[ANCHO-1]) &&
                            (suma_ab[ANCHO-1] != datoRN[ANCHO-1]);
            end
            4'b0011: res_c = datoRN ^ datoRM;
            4'b0100: begin
                res_c     = resta_ab[ANCHO-1:0];
                acarreo_c = ~resta_ab[ANCHO];
                desb_c    = (datoRN[ANCHO-1] != datoRM[ANCHO-1]) &&
                            (resta_ab[ANCHO-1] != datoRN[ANCHO-1]);
            end
            4'b0101: res_c = {{(ANCHO-1){1'b0}}, slt};
            4'b0110: res_c = datoRN << datoRM[SH-1:0];
            4'b0111: res_c = datoRN >> datoRM[SH-1:0];
            4'b1000: res_c = datoRM;
            // Only reached with RM=0; nonzero divisors take the iterative path
            4'b1010: begin
                res_c     = '1;
                alto_c    = datoRN;
                divcero_c = 1'b1;
            end
            default: res_c = '0;
        endcase
    end

    // One shift-add (hi:lo holds partial product, multiplier in lo) or
    // one restoring-divide step (hi is remainder, lo shifts in quotient bits)
    always_comb begin
        suma_it  = {1'b0, hi} + {1'b0, (lo[0] ? m : '0)};
        desp     = {hi, lo[ANCHO-1]};
        resta_it = desp - {1'b0, m};
        if (es_mul) begin
            hi_n = suma_it[ANCHO:1];
            lo_n = {suma_it[0], lo[ANCHO-1:1]};
        end else if (desp >= {1'b0, m}) begin
            hi_n = resta_it[ANCHO-1:0];
            lo_n = {lo[ANCHO-2:0], 1'b1};
        end else begin
            hi_n = desp[ANCHO-1:0];
            lo_n = {lo[ANCHO-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= REPOSO;
            cuenta         <= '0;
            es_mul         <= 1'b0;
            m              <= '0;
            hi             <= '0;
            lo             <= '0;
            listo          <= 1'b1;
            valido         <= 1'b0;
            resultadoALU   <= '0;
            resultadoAlto  <= '0;
            zero           <= 1'b1;
            negativo       <= 1'b0;
            acarreo        <= 1'b0;
            desbordamiento <= 1'b0;
            divCero        <= 1'b0;
        end else begin
            valido <= 1'b0;
            case (estado)
                REPOSO: begin
                    if (inicio && iterativo) begin
                        es_mul <= (aluOP == 4'b1001);
                        m      <= (aluOP == 4'b1001) ? datoRN : datoRM;
                        lo     <= (aluOP == 4'b1001) ? datoRM : datoRN;
                        hi     <= '0;
                        cuenta <= CW'(ANCHO);
                        listo  <= 1'b0;
                        estado <= ITERA;
                    end else if (inicio) begin
                        resultadoALU   <= res_c;
                        resultadoAlto  <= alto_c;
                        zero           <= (res_c == '0);
                        negativo       <= res_c[ANCHO-1];
                        acarreo        <= acarreo_c;
                        desbordamiento <= desb_c;
                        divCero        <= divcero_c;
                        valido         <= 1'b1;
                    end
                end
                ITERA: begin
                    hi     <= hi_n;
                    lo     <= lo_n;
                    cuenta <= cuenta - CW'(1);
                    if (cuenta == CW'(1)) begin
                        resultadoALU   <= lo_n;
                        resultadoAlto  <= hi_n;
                        zero           <= (lo_n == '0);
                        negativo       <= lo_n[ANCHO-1];
                        acarreo        <= 1'b0;
                        desbordamiento <= 1'b0;
                        divCero        <= 1'b0;
                        valido         <= 1'b1;
                        listo          <= 1'b1;
                        estado         <= REPOSO;
                    end
                end
                default: estado <= REPOSO;
            endcase
        end
    end

endmodule

// File: doc/alu_secuencial.md
# alu_secuencial

Parametrised successor to the 64-bit combinational ALU of the datapath: a registered execute unit with a start/done handshake that adds iterative unsigned multiply and divide to the single-cycle logic and arithmetic operations. It sits in the execute stage between the register-file read ports (`datoRN`, `datoRM`) and the write-back multiplexer. The control unit stalls on `listo` while a multi-cycle operation is in flight.

## Interface
- `ANCHO`, 64, datapath width in bits (≥8, power of two)
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `inicio`  in  1  start strobe; accepted only when `listo`=1
- `aluOP`  in  4  operation code, sampled with `inicio`
- `datoRN`  in  ANCHO  operand A, sampled with `inicio`
- `datoRM`  in  ANCHO  operand B, sampled with `inicio`
- `listo`  out  1  unit idle, can accept `inicio`
- `valido`  out  1  one-cycle pulse: results and flags updated
- `resultadoALU`  out  ANCHO  main result (low product, quotient)
- `resultadoAlto`  out  ANCHO  high product / remainder; 0 for other ops
- `zero`, `negativo`, `acarreo`, `desbordamiento`, `divCero`  out  1 each  status flags

## Operation
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 SUB (RN−RM).
  - 0101 SLT (signed, result 1/0).
  - 0110 LSL and 0111 LSR, shift amount RM[log2(ANCHO)-1:0].
  - 1000 PASS RM.
  - 1001 MUL: unsigned, 2·ANCHO product, shift-add.
  - 1010 UDIV: unsigned, restoring.
  - 1011–1111 reserved: result 0, all flags 0 except `zero`=1.
- FSM states:
  - REPOSO, `listo`=1.
    - Single-cycle op, reserved op, or UDIV with RM=0: stays in REPOSO.
    - MUL, or UDIV with RM≠0: goes to ITERA.
  - ITERA, `listo`=0: down-counter loaded with ANCHO at accept; one iteration per cycle. At the edge where the counter reaches 0, results are written, `valido` pulses, and the FSM returns to REPOSO.
- `inicio` while `listo`=0 is ignored; no queueing.
- Operand changes during ITERA do not affect the result, because operands are latched at accept.
- Flags are computed from the final registered result:
  - `zero`: `resultadoALU`==0 (low half only for MUL).
  - `negativo`: `resultadoALU[ANCHO-1]`.
  - `acarreo`: ADD carry-out; SUB no-borrow (RN≥RM unsigned); 0 otherwise.
  - `desbordamiento`: signed overflow for ADD/SUB; 0 otherwise.
  - `divCero`: 1 only for UDIV with RM=0.
- Division by zero: quotient all-ones, remainder = RN, `divCero`=1.
- All arithmetic is modulo 2^ANCHO; no saturation.
- Results and flags hold their last value until the next `valido`.

## Timing
- Reset values:
  - `listo`=1, `valido`=0.
  - `resultadoALU`=0, `resultadoAlto`=0.
  - `zero`=1; `negativo`, `acarreo`, `desbordamiento`, `divCero`=0.
  - FSM in REPOSO, counter=0.
- Single-cycle ops, reserved ops and divide-by-zero:
  - Accepted at edge k; outputs valid and `valido`=1 during cycle k+1 (latency 1).
  - `listo` stays 1, so back-to-back issue every cycle is allowed, with `valido` high continuously.
- MUL and UDIV (RM≠0):
  - Accepted at edge k; `listo`=0 from cycle k+1.
  - Results written at edge k+ANCHO; `valido`=1 and `listo`=1 during cycle k+ANCHO+1 (latency ANCHO).
  - A new `inicio` in that same cycle is accepted.
- `reset` asserted mid-ITERA aborts the operation at the next edge: all outputs return to reset values and no `valido` is issued.
- `reset` has priority over `inicio` on the same edge.

## Test plan
- ADD, ANCHO=64: RN=10, RM=3 → `resultadoALU`=13, `valido` 1 cycle after accept, all flags 0. Follow on the next cycle with SUB 3−10 → 0xFFFF_FFFF_FFFF_FFF9, `negativo`=1, `acarreo`=0.
- Signed overflow: ADD 0x7FFF_FFFF_FFFF_FFFF + 1 → 0x8000_0000_0000_0000, `desbordamiento`=1, `negativo`=1. ADD 0xFFFF…FFFF + 1 → 0, `zero`=1, `acarreo`=1.
- MUL 10×3 → low=30, high=0, `listo`=0 for exactly 64 cycles, `valido` in cycle 65. MUL 0xFFFF…FFFF × 2 → low=0xFFFF…FFFE, high=1.
- UDIV 10/3 → quotient 3, remainder 1, latency 64. UDIV 10/0 → quotient all-ones, remainder 10, `divCero`=1, latency 1.
- `inicio` pulsed with ADD at cycle 5 of a MUL: ignored, and the MUL result is unchanged. Operands changed during ITERA do not affect the result.
- `reset` at cycle 20 of a UDIV: next cycle `listo`=1, results 0, `zero`=1, no `valido` pulse. A following ADD completes normally.
